stream_fifo: RTL and testbench
==============================

Name: stream_fifo

Overview:
Synchronous valid/ready stream FIFO. It is the DUT instantiated in the UVM testbench template, sitting directly under the test layer: agents drive the input stream and monitor the output stream. It buffers up to DEPTH words, exposes fill level and almost-full status, and supports a synchronous flush. It is the reference DUT that the template's tests, sequences and scoreboard are written against.

Parameters:
DATA_W, 32, data word width in bits (>=1)
DEPTH, 8, number of storage entries; power of two, >=2
AF_THRESH, 6, almost_full asserts when level >= AF_THRESH (1..DEPTH)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents
in_valid  in  1  upstream word valid
in_data  in  DATA_W  upstream word
in_ready  out  1  FIFO can accept a word
out_valid  out  1  FIFO holds a word at head
out_data  out  DATA_W  head word
out_ready  in  1  downstream accepts head word
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  out  1  level >= AF_THRESH
overflow_cnt  out  16  count of cycles with in_valid=1 while in_ready=0, saturating

Behaviour:
- Reset (rst_n=0, async assert, sync-released internally via the flops' clocked behaviour): wr_ptr=rd_ptr=0, level=0, in_ready=1, out_valid=0, almost_full=0, overflow_cnt=0. out_data is 0 after reset; storage contents are not cleared.
- Pointers: log2(DEPTH)+1 bits, including a wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ.
- in_ready = !full, taken from registered state only. There is no combinational path from out_ready to in_ready.
- out_valid = !empty. out_data = mem[rd_ptr low bits]; this is first-word fall-through from the storage array.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- On push: mem[wr_ptr] <= in_data and wr_ptr increments modulo 2*DEPTH.
- On pop: rd_ptr increments.
- Push and pop in the same cycle (only possible when not empty and not full): level is unchanged and both pointers advance.
- Latency: a word pushed in cycle N is visible on out_valid/out_data in cycle N+1 when the FIFO was empty.
- Full: in_ready=0. A pop in that cycle does not enable a same-cycle push; in_ready rises the following cycle.
- Empty: out_valid=0 and out_ready is ignored.
- level: registered; +1 on push only, -1 on pop only. almost_full is derived from the registered level.
- out_data stability: while out_valid=1 and out_ready=0, out_data must hold. Writes never target the head entry unless the FIFO is empty.
- flush=1: at the next edge, pointers and level go to 0, out_valid=0 and in_ready=1. flush has priority over a push or pop in the same cycle, and both are discarded. overflow_cnt is not cleared.
- overflow_cnt: increments each cycle with in_valid=1 & in_ready=0 and saturates at 16'hFFFF.
- Reset mid-stream: all state clears immediately on the rst_n falling edge, with no dependence on clk.
- in_data is sampled only on push; X on in_data while in_valid=0 must not propagate.

Test Plan:
- Reset: after rst_n low then high, expect level=0, in_ready=1, out_valid=0, overflow_cnt=0.
- Single word: push 32'hDEADBEEF with out_ready=0 -> next cycle out_valid=1, out_data=DEADBEEF, level=1. Assert out_ready for one cycle -> out_valid=0, level=0.
- Fill: push 0..7 back-to-back with out_ready=0 -> almost_full=1 once level=6, in_ready=0 at level=8. Hold in_valid=1 for 3 more cycles -> overflow_cnt=3. Drain -> data 0..7 in order.
- Concurrent: keep level at 4 and push/pop every cycle for 20 cycles -> level stays 4, and the output sequence matches input order across pointer wrap.
- Full + pop: at level=8, assert out_ready and in_valid together -> in that cycle only the pop occurs (level=7). The push is accepted the next cycle (level=8).
- Flush/reset mid-op: at level=5, assert flush together with push and pop -> next cycle level=0 and out_valid=0. Separately, drop rst_n between clock edges -> outputs clear without waiting for a clock edge.

Source files
------------

// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready stream FIFO with first-word fall-through output,
// fill level, almost-full status, synchronous flush and a saturating
// overflow counter. Pointers carry an extra wrap bit to tell full from empty.
module stream_fifo #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic [15:0]              overflow_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q,  level_d;
    logic [15:0]   ovf_q,    ovf_d;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;

    // Status decode, handshakes and output view, all from registered state.
    always_comb begin
        wr_idx      = wr_ptr_q[AW-1:0];
        rd_idx      = rd_ptr_q[AW-1:0];
        empty       = (wr_ptr_q == rd_ptr_q);
        full        = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        in_ready    = !full;
        out_valid   = !empty;
        push        = in_valid && !full;
        pop         = !empty && out_ready;
        // Flush discards a same-cycle push, so the array is left untouched too.
        wr_en       = push && !flush;
        // Head is masked while empty so out_data reads 0 after reset/flush
        // without having to clear the storage array.
        out_data    = empty ? '0 : mem_q[rd_idx];
        level       = level_q;
        almost_full = (level_q >= PW'(AF_THRESH));
        overflow_cnt = ovf_q;
    end

    // Next-state for pointers, level and overflow counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + PW'(1);
                2'b01:   level_d = level_q - PW'(1);
                default: level_d = level_q;
            endcase
        end

        if (in_valid && full && (ovf_q != '1)) ovf_d = ovf_q + 16'd1;
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= in_data;
    end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed stimulus with a queue scoreboard for stream_fifo.
module tb_stream_fifo;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned AF_THRESH = 6;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [3:0]        level;
    logic              almost_full;
    logic [15:0]       overflow_cnt;

    int unsigned n_tests;
    int unsigned n_fail;

    logic [DATA_W-1:0] sb_q[$];
    int unsigned       m_ovf;

    stream_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .level        (level),
        .almost_full  (almost_full),
        .overflow_cnt (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the scoreboard model.
    task automatic chk_model(input string tag);
        int unsigned ml;
        ml = sb_q.size();
        chk({tag, ".level"},     32'(level),        32'(ml));
        chk({tag, ".in_ready"},  32'(in_ready),     32'(ml < DEPTH));
        chk({tag, ".out_valid"}, 32'(out_valid),    32'(ml != 0));
        chk({tag, ".af"},        32'(almost_full),  32'(ml >= AF_THRESH));
        chk({tag, ".ovf"},       32'(overflow_cnt), m_ovf);
        if (ml != 0) chk({tag, ".data"}, out_data, sb_q[0]);
        else         chk({tag, ".data0"}, out_data, 32'h0);
    endtask

    // One clock cycle: check outputs, apply inputs, update model, advance.
    task automatic cyc(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
        bit m_push, m_pop, m_full;
        chk_model("pre");
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        m_full = (sb_q.size() == DEPTH);
        m_push = iv && !m_full;
        m_pop  = ordy && (sb_q.size() != 0);
        if (iv && m_full && m_ovf != 32'hFFFF) m_ovf++;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (m_pop)  void'(sb_q.pop_front());
            if (m_push) sb_q.push_back(id);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = 'x;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        m_ovf     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst.level",     32'(level),        32'd0);
        chk("rst.in_ready",  32'(in_ready),     32'd1);
        chk("rst.out_valid", 32'(out_valid),    32'd0);
        chk("rst.af",        32'(almost_full),  32'd0);
        chk("rst.ovf",       32'(overflow_cnt), 32'd0);
        chk("rst.data",      out_data,          32'd0);

        // Single word, one-cycle fall-through
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("single.valid", 32'(out_valid), 32'd1);
        chk("single.data",  out_data,       32'hDEADBEEF);
        chk("single.level", 32'(level),     32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("single.empty", 32'(out_valid), 32'd0);
        chk("single.lvl0",  32'(level),     32'd0);

        // Fill to full
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 1'b0);
            if (i == 5) chk("fill.af6", 32'(almost_full), 32'd1);
            if (i == 4) chk("fill.af5", 32'(almost_full), 32'd0);
        end
        chk("fill.in_ready", 32'(in_ready), 32'd0);
        chk("fill.level8",   32'(level),    32'd8);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hBAD0_0000 + 32'(i), 1'b0, 1'b0);
        chk("fill.ovf3", 32'(overflow_cnt), 32'd3);

        // Full + pop: only the pop happens this cycle
        cyc(1'b1, 32'h0000_0100, 1'b1, 1'b0);
        chk("fullpop.level7", 32'(level),    32'd7);
        chk("fullpop.ready",  32'(in_ready), 32'd1);
        chk("fullpop.ovf4",   32'(overflow_cnt), 32'd4);
        cyc(1'b1, 32'h0000_0100, 1'b0, 1'b0);
        chk("fullpop.level8", 32'(level), 32'd8);

        // Drain in order
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain.empty", 32'(out_valid), 32'd0);

        // Concurrent push/pop at level 4 across pointer wrap
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, $urandom(), 1'b1, 1'b0);
        chk("conc.level4", 32'(level), 32'd4);

        // Flush with simultaneous push and pop at level 5
        cyc(1'b1, 32'h5555_5555, 1'b0, 1'b0);
        chk("flush.pre5", 32'(level), 32'd5);
        cyc(1'b1, 32'hF1F1_F1F1, 1'b1, 1'b1);
        chk("flush.level0", 32'(level),        32'd0);
        chk("flush.valid0", 32'(out_valid),    32'd0);
        chk("flush.ready",  32'(in_ready),     32'd1);
        chk("flush.ovf",    32'(overflow_cnt), 32'd4);

        // Idle with X on in_data must not disturb state
        for (int i = 0; i < 3; i++) cyc(1'b0, 'x, 1'b0, 1'b0);
        cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        cyc(1'b1, 32'h9ABC_DEF0, 1'b0, 1'b0);
        chk("xidle.data", out_data, 32'h1234_5678);
        cyc(1'b0, 'x, 1'b1, 1'b0);
        chk_model("xidle.post");

        // Asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1;
        chk("arst.level", 32'(level),        32'd0);
        chk("arst.valid", 32'(out_valid),    32'd0);
        chk("arst.ready", 32'(in_ready),     32'd1);
        chk("arst.ovf",   32'(overflow_cnt), 32'd0);
        chk("arst.data",  out_data,          32'd0);
        sb_q.delete();
        m_ovf = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk_model("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
